mem_arbiter: RTL and testbench

Shares one single-port memory bus between the OpenMIPS instruction-fetch port and data port inside `openmips_min_sopc`, so one unified RAM replaces separate ROM and RAM. Arbitration uses data-over-instruction priority plus alternation, so neither port starves. The block runs the memory req/ack handshake and returns registered read data with a one-cycle ack pulse. While any requester is waiting, it asserts a stall request to the pipeline controller.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/defines.sv | 7 +
 rtl/mem_arbiter_wdog.sv | 30 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int ARB_ADDR_W      = 32;
    localparam int ARB_DATA_W      = 32;
    localparam int ARB_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the arbiter and the unified RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ARB_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::ARB_DATA_W
);
    // Handshake: i_req/d_req and their command fields are held until the matching
    // x_ack, a one-cycle pulse during which x_rdata is valid; m_req and the m_*
    // command are held until the single-cycle m_ack strobe from the memory.
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic                d_req;
    logic                d_we;
    logic [DATA_W/8-1:0] d_sel;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_ack;

    logic                m_req;
    logic                m_we;
    logic [DATA_W/8-1:0] m_sel;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_ack;

    logic       stall_req;
    logic       bus_err;
    logic [1:0] dbg_state;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack,
        output m_req, m_we, m_sel, m_addr, m_wdata,
        output stall_req, bus_err, dbg_state
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  m_req, m_we, m_sel, m_addr, m_wdata,
        input  stall_req, bus_err, dbg_state
    );
endinterface

// File: rtl/defines.sv
// Global OpenMIPS-style macros shared by the SoC blocks (reset polarity).
`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef RstDisable
`define RstDisable 1'b0
`endif

// File: rtl/mem_arbiter_wdog.sv
// arb_wdog: wait-cycle counter for a granted memory access; expired once LIMIT cycles pass.
`ifndef RstEnable
`define RstEnable 1'b1
`endif
module arb_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at LIMIT so expired stays stable until the next grant clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(LIMIT));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the OpenMIPS fetch and data ports.
// Define MEM_ARB_TIMEOUT_EN to abort accesses the memory never acknowledges (bus_err).
`ifndef RstEnable
`define RstEnable 1'b1
`endif
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_GNT_D = GNT_D;
    localparam logic [1:0] ST_GNT_I = GNT_I;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0] state;
    logic       last_d;
    logic       expired;
    logic       pick_d;
    logic       pick_i;

    // Data wins unless it also won last time and a fetch is waiting.
    assign pick_d = bus.d_req & (~bus.i_req | ~last_d);
    assign pick_i = bus.i_req & ~pick_d;

    assign bus.stall_req = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);
    assign bus.dbg_state = state;

`ifdef MEM_ARB_TIMEOUT_EN
    logic granting;
    logic waiting;

    assign granting = (state == ST_IDLE) & (bus.d_req | bus.i_req);
    assign waiting  = (state == ST_GNT_D) | (state == ST_GNT_I);

    arb_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (granting),
        .en      (waiting),
        .expired (expired)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            state       <= ST_IDLE;
            last_d      <= 1'b0;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_sel   <= '0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.i_rdata <= '0;
            bus.i_ack   <= 1'b0;
            bus.d_rdata <= '0;
            bus.d_ack   <= 1'b0;
            bus.bus_err <= 1'b0;
        end else begin
            bus.i_ack   <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_d) begin
                        state       <= ST_GNT_D;
                        last_d      <= 1'b1;
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.d_we;
                        bus.m_sel   <= bus.d_sel;
                        bus.m_addr  <= bus.d_addr;
                        bus.m_wdata <= bus.d_wdata;
                    end else if (pick_i) begin
                        state      <= ST_GNT_I;
                        last_d     <= 1'b0;
                        bus.m_req  <= 1'b1;
                        bus.m_we   <= 1'b0;
                        bus.m_sel  <= '1;
                        bus.m_addr <= bus.i_addr;
                    end
                end
                // A real ack always wins over a coincident timeout.
                ST_GNT_D: begin
                    if (bus.m_ack || expired) begin
                        state       <= ST_RESP;
                        bus.m_req   <= 1'b0;
                        bus.d_ack   <= 1'b1;
                        bus.bus_err <= ~bus.m_ack;
                        if (!bus.m_we) begin
                            bus.d_rdata <= bus.m_ack ? bus.m_rdata : '0;
                        end
                    end
                end
                ST_GNT_I: begin
                    if (bus.m_ack || expired) begin
                        state       <= ST_RESP;
                        bus.m_req   <= 1'b0;
                        bus.i_ack   <= 1'b1;
                        bus.bus_err <= ~bus.m_ack;
                        bus.i_rdata <= bus.m_ack ? bus.m_rdata : '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural single-port RAM model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_val;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / safety net ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    int mem_lat  = 0;
    bit mem_mute = 1'b0;
    bit late_ack = 1'b0;
    int wait_cnt = 0;

    always @(negedge clk) begin
        bus.m_ack = 1'b0;
        if (late_ack) bus.m_ack = 1'b1;
        if (rst || !bus.m_req || mem_mute) begin
            wait_cnt = 0;
        end else if (wait_cnt < mem_lat) begin
            wait_cnt++;
        end else begin
            wait_cnt  = 0;
            bus.m_ack = 1'b1;
            if (bus.m_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.m_sel[b]) mem[bus.m_addr[9:2]][8*b +: 8] = bus.m_wdata[8*b +: 8];
            end else begin
                bus.m_rdata = mem[bus.m_addr[9:2]];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_d(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_sel   = sel;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
    endtask

    task automatic drive_i(input logic [31:0] addr);
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
    endtask

    // Called at the negedge of cycle 'start'; returns at the negedge where the ack is seen.
    task automatic wait_ack(input bit is_d, input int start, input int budget, output int cyc);
        cyc = start;
        while (!(is_d ? bus.d_ack : bus.i_ack) && cyc < start + budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE);
        end
        checks++;
        if ({bus.m_req, bus.m_we, bus.i_ack, bus.d_ack, bus.bus_err, bus.stall_req} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.m_req, bus.m_we, bus.i_ack, bus.d_ack, bus.bus_err, bus.stall_req});
        end
        checks++;
        if ({bus.m_addr, bus.m_wdata, bus.m_sel} !== 68'h0) begin
            errors++; $display("FAIL reset_cmd: got %h expected 0", {bus.m_addr, bus.m_wdata, bus.m_sel});
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", {bus.i_rdata, bus.d_rdata});
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_write();
        int cyc;
        @(posedge clk); #1;
        mem_lat = 0;
        exp_q.push_back(32'h0);              // d_rdata untouched by a write
        drive_d(1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (bus.stall_req !== 1'b1) begin
            errors++; $display("FAIL wr_stall: got %b expected 1", bus.stall_req);
        end
        @(negedge clk);
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_sel} !== 6'b110011) begin
            errors++; $display("FAIL wr_cmd: got %b expected 110011", {bus.m_req, bus.m_we, bus.m_sel});
        end
        checks++;
        if (bus.m_addr !== 32'h100 || bus.m_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_addr_data: got %h/%h expected 100/deadbeef", bus.m_addr, bus.m_wdata);
        end
        wait_ack(1'b1, 1, 20, cyc);
        checks++;
        if (cyc != 2) begin
            errors++; $display("FAIL wr_latency: got cycle %0d expected 2", cyc);
        end
        exp_val = exp_q.pop_front();
        checks++;
        if (bus.d_rdata !== exp_val) begin
            errors++; $display("FAIL wr_rdata_hold: got %h expected %h", bus.d_rdata, exp_val);
        end
        @(posedge clk); #1 bus.d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.d_ack !== 1'b0) begin
            errors++; $display("FAIL wr_ack_pulse: got %b expected 0", bus.d_ack);
        end
    endtask

    task automatic test_read();
        int cyc;
        @(posedge clk); #1;
        mem_lat = 1;
        exp_q.push_back(32'hA500_BEEF);      // preload A5000040 with the low two bytes written
        drive_d(1'b0, 4'hF, 32'h100, 32'h0);
        @(negedge clk);
        wait_ack(1'b1, 0, 20, cyc);
        checks++;
        if (cyc != 3) begin
            errors++; $display("FAIL rd_latency: got cycle %0d expected 3", cyc);
        end
        exp_val = exp_q.pop_front();
        checks++;
        if (bus.d_rdata !== exp_val) begin
            errors++; $display("FAIL rd_data: got %h expected %h", bus.d_rdata, exp_val);
        end
        @(posedge clk); #1 bus.d_req = 1'b0;
    endtask

    task automatic test_fetch();
        int cyc;
        @(posedge clk); #1;
        mem_lat = 2;
        exp_q.push_back(32'h3401_1100);
        drive_i(32'h0000_0010);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_sel} !== 6'b101111 || bus.m_addr !== 32'h10) begin
            errors++;
            $display("FAIL if_cmd: got %b addr %h expected 101111 addr 10",
                     {bus.m_req, bus.m_we, bus.m_sel}, bus.m_addr);
        end
        wait_ack(1'b0, 1, 20, cyc);
        checks++;
        if (cyc != 4) begin
            errors++; $display("FAIL if_latency: got cycle %0d expected 4", cyc);
        end
        exp_val = exp_q.pop_front();
        checks++;
        if (bus.i_rdata !== exp_val) begin
            errors++; $display("FAIL if_data: got %h expected %h", bus.i_rdata, exp_val);
        end
        @(posedge clk); #1 bus.i_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   cyc, acks, last_cyc, stall_bad;
        logic prev_req;
        @(posedge clk); #1;
        mem_lat = 0;
        exp_q.delete();
        exp_q.push_back(32'(GNT_D));
        exp_q.push_back(32'(GNT_I));
        exp_q.push_back(32'(GNT_D));
        exp_q.push_back(32'(GNT_I));
        drive_d(1'b0, 4'hF, 32'h40, 32'h0);
        drive_i(32'h20);
        cyc = 0; acks = 0; last_cyc = -1; stall_bad = 0; prev_req = 1'b0;
        while (acks < 4 && cyc < 40) begin
            @(negedge clk);
            if (bus.m_req && !prev_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_grant: got state %0d expected none", bus.dbg_state);
                end else begin
                    exp_val = exp_q.pop_front();
                    if (32'(bus.dbg_state) !== exp_val) begin
                        errors++; $display("FAIL b2b_order: got %0d expected %0d", bus.dbg_state, exp_val);
                    end
                end
            end
            prev_req = bus.m_req;
            if (bus.stall_req !== 1'b1) stall_bad++;
            if (bus.d_ack) begin
                checks++;
                if (bus.d_rdata !== 32'hA500_0010) begin
                    errors++; $display("FAIL b2b_d_data: got %h expected a5000010", bus.d_rdata);
                end
                acks++; last_cyc = cyc;
            end
            if (bus.i_ack) begin
                checks++;
                if (bus.i_rdata !== 32'hA500_0008) begin
                    errors++; $display("FAIL b2b_i_data: got %h expected a5000008", bus.i_rdata);
                end
                acks++; last_cyc = cyc;
            end
            cyc++;
        end
        checks++;
        if (acks != 4 || last_cyc != 11) begin
            errors++; $display("FAIL b2b_timing: got %0d acks last at %0d expected 4 at 11", acks, last_cyc);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_missing_grant: got %0d left expected 0", exp_q.size());
        end
        checks++;
        if (stall_bad != 0) begin
            errors++; $display("FAIL b2b_stall: got %0d low cycles expected 0", stall_bad);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall_req !== 1'b0 || bus.dbg_state !== IDLE) begin
            errors++;
            $display("FAIL b2b_drain: got stall %b state %0d expected 0/%0d", bus.stall_req, bus.dbg_state, IDLE);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(posedge clk); #1;
        mem_mute = 1'b1;
        drive_d(1'b0, 4'hF, 32'h80, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.dbg_state !== GNT_D || bus.m_req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_grant: got state %0d m_req %b expected %0d/1", bus.dbg_state, bus.m_req, GNT_D);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.m_req !== 1'b0 || bus.dbg_state !== IDLE || bus.d_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got m_req %b state %0d d_ack %b expected 0/%0d/0",
                     bus.m_req, bus.dbg_state, bus.d_ack, IDLE);
        end
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b0;
        mem_mute = 1'b0;
        late_ack = 1'b1;
        @(posedge clk); #1 late_ack = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.dbg_state !== IDLE || bus.m_req !== 1'b0 || bus.d_ack !== 1'b0 ||
                bus.i_ack !== 1'b0 || bus.bus_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rst_mid_late_ack: got %0d disturbed cycles expected 0", bad);
        end
    endtask

    task automatic test_no_ack();
        @(posedge clk); #1;
        mem_mute = 1'b1;
        drive_i(32'h30);
        @(negedge clk);
        @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int cyc;
            exp_q.push_back(32'h0);
            wait_ack(1'b0, 1, 30, cyc);
            checks++;
            if (cyc != 10) begin
                errors++; $display("FAIL to_latency: got cycle %0d expected 10", cyc);
            end
            checks++;
            if (bus.bus_err !== 1'b1 || bus.m_req !== 1'b0) begin
                errors++; $display("FAIL to_bus_err: got err %b m_req %b expected 1/0", bus.bus_err, bus.m_req);
            end
            exp_val = exp_q.pop_front();
            checks++;
            if (bus.i_rdata !== exp_val) begin
                errors++; $display("FAIL to_rdata: got %h expected %h", bus.i_rdata, exp_val);
            end
            @(posedge clk); #1 bus.i_req = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.bus_err !== 1'b0 || bus.i_ack !== 1'b0) begin
                errors++; $display("FAIL to_pulse: got err %b ack %b expected 0/0", bus.bus_err, bus.i_ack);
            end
        end
`else
        begin
            int bad;
            bad = 0;
            for (int n = 0; n < 100; n++) begin
                if (bus.m_req !== 1'b1 || bus.stall_req !== 1'b1 || bus.bus_err !== 1'b0 ||
                    bus.i_ack !== 1'b0) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL noack_hold: got %0d bad cycles expected 0", bad);
            end
            bus.i_req = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
        end
`endif
        mem_mute = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_sel   = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[4] = 32'h3401_1100;

        test_reset();
        test_write();
        test_read();
        test_fetch();
        test_back_to_back();
        test_reset_mid();
        test_no_ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
